// File: rtl/fast_pkg.sv
// Shared types for the FAST keypoint pipeline: NMS state, keypoint record and counter width.
package fast_pkg;

  localparam int unsigned KP_COUNT_W = 16;
  localparam int unsigned KP_FIELD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fast_nms_state_t;

  typedef struct packed {
    logic [KP_FIELD_W-1:0] x;
    logic [KP_FIELD_W-1:0] y;
    logic [KP_FIELD_W-1:0] score;
  } fast_kp_t;

endpackage

// File: rtl/fast_nms_linebuf.sv
// Two-row score delay line: {row y-1, row y-2} per column, read-before-write at addr.
module fast_nms_linebuf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 640
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(IMG_WIDTH)-1:0]  addr,
  input  logic [2*DATA_WIDTH-1:0]       wdata,
  output logic [2*DATA_WIDTH-1:0]       rdata_c
);

  logic [2*DATA_WIDTH-1:0] mem [IMG_WIDTH];

  // Contents are masked by row position downstream, so no reset is needed.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/fast_nms.sv
// 3x3 non-maximum suppression on the FAST score raster, emitting sparse (x, y, score) keypoints.
// Optional per-frame keypoint cap enabled by defining FAST_NMS_KP_LIMIT_EN.
module fast_nms
  import fast_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned MAX_KP     = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sof,
  input  logic                           in_valid,
  input  logic                           is_corner,
  input  logic [DATA_WIDTH-1:0]          score,
  output logic                           kp_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]   kp_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]  kp_y,
  output logic [DATA_WIDTH-1:0]          kp_score,
  output logic                           busy,
  output logic                           frame_done,
  output logic [KP_COUNT_W-1:0]          kp_count,
  output logic                           proto_err
);

  localparam int unsigned X_W  = $clog2(IMG_WIDTH);
  localparam int unsigned Y_W  = $clog2(IMG_HEIGHT);
  // Row counter must also reach the two virtual flush rows.
  localparam int unsigned YC_W = $clog2(IMG_HEIGHT + 2);
`ifdef FAST_NMS_KP_LIMIT_EN
  localparam bit KP_LIMIT = 1'b1;
`else
  localparam bit KP_LIMIT = 1'b0;
`endif

  fast_nms_state_t state_q;
  logic [X_W-1:0]  x_q, cur_x, ctr_x;
  logic [YC_W-1:0] y_q, cur_y, ctr_y;
  logic            restart, virt, step, last_col, eval_c, survive_c, limit_ok, emit_c;
  logic [DATA_WIDTH-1:0]   s_new;
  logic [2*DATA_WIDTH-1:0] lb_rd;
  // Columns indexed 0 = row above center, 1 = center row, 2 = row below.
  logic [DATA_WIDTH-1:0] col_new [3];
  logic [DATA_WIDTH-1:0] col_l   [3];
  logic [DATA_WIDTH-1:0] col_c   [3];
  logic [DATA_WIDTH-1:0] win_l   [3];
  logic [DATA_WIDTH-1:0] win_r   [3];

  fast_nms_linebuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH)
  ) u_linebuf (
    .clk     (clk),
    .we      (step),
    .addr    (cur_x),
    .wdata   ({s_new, lb_rd[2*DATA_WIDTH-1:DATA_WIDTH]}),
    .rdata_c (lb_rd)
  );

  // Input acceptance, window assembly and the suppression compare tree.
  always_comb begin
    restart  = in_valid & sof;
    virt     = (state_q == FLUSH) & ~restart;
    step     = restart | virt | ((state_q == RUN) & in_valid);
    cur_x    = restart ? '0 : x_q;
    cur_y    = restart ? '0 : y_q;
    last_col = (cur_x == X_W'(IMG_WIDTH - 1));
    s_new    = (virt || !is_corner) ? '0 : score;

    col_new[0] = (cur_y >= YC_W'(2)) ? lb_rd[DATA_WIDTH-1:0] : '0;
    col_new[1] = (cur_y != '0) ? lb_rd[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    col_new[2] = s_new;
    for (int i = 0; i < 3; i++) begin
      win_l[i] = (cur_x == X_W'(1)) ? '0 : col_l[i];
      win_r[i] = (cur_x == '0) ? '0 : col_new[i];
    end

    eval_c = step & (((cur_x != '0) && (cur_y != '0)) ||
                     ((cur_x == '0) && (cur_y >= YC_W'(2))));
    // Strict against raster-earlier neighbours so a plateau keeps only its first pixel.
    survive_c = (col_c[1] != '0) &&
                (col_c[1] >  win_l[0]) && (col_c[1] >  col_c[0]) && (col_c[1] >  win_r[0]) &&
                (col_c[1] >  win_l[1]) && (col_c[1] >= win_r[1]) &&
                (col_c[1] >= win_l[2]) && (col_c[1] >= col_c[2]) && (col_c[1] >= win_r[2]);
    ctr_x    = (cur_x == '0) ? X_W'(IMG_WIDTH - 1) : cur_x - X_W'(1);
    ctr_y    = (cur_x == '0) ? cur_y - YC_W'(2) : cur_y - YC_W'(1);
    limit_ok = !KP_LIMIT || (kp_count < KP_COUNT_W'(MAX_KP));
    emit_c   = eval_c & survive_c & limit_ok;
  end

  // FSM, coordinate counters, window shift and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      col_l      <= '{default: '0};
      col_c      <= '{default: '0};
      kp_valid   <= 1'b0;
      kp_x       <= '0;
      kp_y       <= '0;
      kp_score   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      kp_count   <= '0;
      proto_err  <= 1'b0;
    end else begin
      kp_valid   <= emit_c;
      frame_done <= 1'b0;
      if (emit_c) begin
        kp_x     <= ctr_x;
        kp_y     <= Y_W'(ctr_y);
        kp_score <= col_c[1];
      end

      if (restart) kp_count <= '0;
      else if (emit_c && (kp_count != '1)) kp_count <= kp_count + KP_COUNT_W'(1);

      if ((restart && (state_q != IDLE)) || (in_valid && (state_q == FLUSH))) proto_err <= 1'b1;

      if (step) begin
        col_l <= col_c;
        col_c <= col_new;
        x_q   <= last_col ? '0 : cur_x + X_W'(1);
        y_q   <= last_col ? cur_y + YC_W'(1) : cur_y;
      end

      if (restart) begin
        state_q <= RUN;
        busy    <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            if (in_valid && last_col && (cur_y == YC_W'(IMG_HEIGHT - 1))) state_q <= FLUSH;
          end
          FLUSH: begin
            if (cur_y == YC_W'(IMG_HEIGHT + 1)) begin
              state_q    <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fast_nms.sv
// Scoreboard bench for fast_nms on an 8x6 image: directed frames, queued expected keypoints.
`timescale 1ns/1ps
module tb_fast_nms;
  import fast_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sof = 1'b0;
  logic        in_valid = 1'b0;
  logic        is_corner = 1'b0;
  logic [7:0]  score = '0;
  logic        kp_valid;
  logic [2:0]  kp_x;
  logic [2:0]  kp_y;
  logic [7:0]  kp_score;
  logic        busy;
  logic        frame_done;
  logic [15:0] kp_count;
  logic        proto_err;

  fast_nms #(
    .DATA_WIDTH (8),
    .IMG_WIDTH  (8),
    .IMG_HEIGHT (6),
    .MAX_KP     (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sof        (sof),
    .in_valid   (in_valid),
    .is_corner  (is_corner),
    .score      (score),
    .kp_valid   (kp_valid),
    .kp_x       (kp_x),
    .kp_y       (kp_y),
    .kp_score   (kp_score),
    .busy       (busy),
    .frame_done (frame_done),
    .kp_count   (kp_count),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_edge = 0;
  int d0 = 0;
  fast_kp_t exp_q[$];
  fast_kp_t e;
  logic [7:0] fr_score [48];
  logic       fr_corner [48];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every presented keypoint must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (kp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL kp_unexpected got (%0d,%0d,%0d) want none", kp_x, kp_y, kp_score);
        end else begin
          e = exp_q.pop_front();
          if ((16'(kp_x) != e.x) || (16'(kp_y) != e.y) || (16'(kp_score) != e.score)) begin
            errors++;
            $display("FAIL kp got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     kp_x, kp_y, kp_score, e.x, e.y, e.score);
          end
        end
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 48; i++) begin
      fr_score[i]  = 8'd0;
      fr_corner[i] = 1'b0;
    end
  endtask

  task automatic set_px(input int x, input int y, input int s, input bit c);
    fr_score[y*8 + x]  = 8'(s);
    fr_corner[y*8 + x] = c;
  endtask

  task automatic push_kp(input int x, input int y, input int s);
    fast_kp_t k;
    k.x = 16'(x);
    k.y = 16'(y);
    k.score = 16'(s);
    exp_q.push_back(k);
  endtask

  task automatic drive_frame(input int npix, input int extra);
    for (int i = 0; i < npix; i++) begin
      @(posedge clk); #1;
      if (i == 24) chk("busy_run", 32'(busy), 32'd1);
      in_valid  = 1'b1;
      sof       = (i == 0);
      is_corner = fr_corner[i];
      score     = fr_score[i];
      if (i == 47) last_edge = cyc + 1;
    end
    for (int i = 0; i < extra; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; sof = 1'b0; is_corner = 1'b1; score = 8'd200;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; sof = 1'b0; is_corner = 1'b0; score = 8'd0;
  endtask

  task automatic finish_frame(input string name, input int start_done, input int exp_count);
    int budget;
    budget = 0;
    while ((done_cnt == start_done) && (budget < 40)) begin
      @(negedge clk); #1;
      budget++;
    end
    chk({name, "_done_cnt"}, 32'(done_cnt), 32'(start_done + 1));
    chk({name, "_done_lat"}, 32'(done_cyc - last_edge), 32'd9);
    repeat (3) @(negedge clk);
    #1;
    chk({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk({name, "_kp_count"}, 32'(kp_count), 32'(exp_count));
    chk({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_kp_valid", 32'(kp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_kp_count", 32'(kp_count), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single isolated corner
    clear_frame(); set_px(3, 2, 40, 1); push_kp(3, 2, 40);
    d0 = done_cnt; drive_frame(48, 0); finish_frame("single", d0, 1);

    // Plateaus: first in raster order survives
    clear_frame();
    set_px(4, 3, 25, 1); set_px(5, 3, 25, 1); set_px(2, 1, 25, 1); set_px(2, 2, 25, 1);
    push_kp(2, 1, 25); push_kp(4, 3, 25);
    d0 = done_cnt; drive_frame(48, 0); finish_frame("ties", d0, 2);

    // Neighbour dominance and non-corner masking
    clear_frame();
    set_px(1, 1, 30, 1); set_px(2, 2, 50, 1); set_px(6, 4, 200, 0);
    push_kp(2, 2, 50);
    d0 = done_cnt; drive_frame(48, 0); finish_frame("dominance", d0, 1);

    // Borders and corners of the image
    clear_frame();
    set_px(0, 0, 10, 1); set_px(7, 5, 12, 1); set_px(7, 0, 9, 1);
    push_kp(0, 0, 10); push_kp(7, 0, 9); push_kp(7, 5, 12);
    d0 = done_cnt; drive_frame(48, 0); finish_frame("borders", d0, 3);
    chk("clean_proto_err", 32'(proto_err), 32'd0);

    // Keypoint cap
    clear_frame();
    set_px(1, 1, 20, 1); set_px(4, 1, 21, 1); set_px(1, 4, 22, 1);
    push_kp(1, 1, 20); push_kp(4, 1, 21);
`ifdef FAST_NMS_KP_LIMIT_EN
    d0 = done_cnt; drive_frame(48, 0); finish_frame("limit", d0, 2);
`else
    push_kp(1, 4, 22);
    d0 = done_cnt; drive_frame(48, 0); finish_frame("limit", d0, 3);
`endif

    // sof mid-frame abandons the partial frame
    clear_frame(); set_px(3, 2, 99, 1);
    d0 = done_cnt; drive_frame(20, 0);
    clear_frame(); set_px(5, 4, 77, 1); push_kp(5, 4, 77);
    drive_frame(48, 0); finish_frame("abort", d0, 1);
    chk("abort_proto_err", 32'(proto_err), 32'd1);

    do_reset();
    #1;
    chk("rst2_proto_err", 32'(proto_err), 32'd0);

    // in_valid during flush is dropped but flagged
    clear_frame(); set_px(2, 3, 60, 1); push_kp(2, 3, 60);
    d0 = done_cnt; drive_frame(48, 3); finish_frame("flush_in", d0, 1);
    chk("flush_proto_err", 32'(proto_err), 32'd1);

    // Reset mid-frame
    clear_frame(); set_px(1, 0, 5, 1);
    drive_frame(10, 0);
    chk("mid_kp_count_cleared", 32'(kp_count), 32'd0);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_proto_err", 32'(proto_err), 32'd0);
    chk("midrst_kp_valid", 32'(kp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // in_valid without sof in IDLE is ignored
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; sof = 1'b0; is_corner = 1'b1; score = 8'd90;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; is_corner = 1'b0; score = 8'd0;
    chk("idle_ignore_busy", 32'(busy), 32'd0);

    clear_frame(); set_px(6, 3, 44, 1); push_kp(6, 3, 44);
    d0 = done_cnt; drive_frame(48, 0); finish_frame("after_rst", d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
